// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference if it did not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] q_out
);
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] trial;

  // rem_in < divisor on entry, so rem_shift < 2*divisor and the sign bit of
  // the WIDTH+1 bit difference is an exact borrow flag.
  assign rem_shift = {rem_in[WIDTH-1:0], q_in[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, divisor};

  always_comb begin
    if (trial[WIDTH]) begin
      rem_out = rem_shift;
      q_out   = {q_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = trial;
      q_out   = {q_in[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with registered results.
// Define DIV_EARLY_OUT_EN to skip the iteration loop when divisor==0 or |a|<|b|.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] b_reg;
  logic             q_neg;
  logic             r_neg;
  logic             div0;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  assign abs_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .q_in    (q_reg),
    .divisor (b_reg),
    .rem_out (step_rem),
    .q_out   (step_q)
  );

  // Divide-by-zero forces an all-ones quotient; the remainder path already
  // reproduces the dividend because every trial subtract of zero succeeds.
  assign fix_q = div0  ? '1 : (q_neg ? -q_reg : q_reg);
  assign fix_r = r_neg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

`ifdef DIV_EARLY_OUT_EN
  logic early;
  assign early = (divisor == '0) || (abs_a < abs_b);
`endif

  // NOTE: every register here is state, so all assignments are non-blocking;
  // blocking ones would let later statements see this edge's new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_reg   <= '0;
      q_reg     <= '0;
      b_reg     <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div0      <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (cancel) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            b_reg <= abs_b;
            q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= is_signed & dividend[WIDTH-1];
            div0  <= (divisor == '0);
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            if (early) begin
              rem_reg <= {1'b0, abs_a};
              q_reg   <= '0;
              state   <= FIX;
            end else begin
              rem_reg <= '0;
              q_reg   <= abs_a;
              state   <= BUSY;
            end
`else
            rem_reg <= '0;
            q_reg   <= abs_a;
            state   <= BUSY;
`endif
          end
        end
        BUSY: begin
          rem_reg <= step_rem;
          q_reg   <= step_q;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          quotient  <= fix_q;
          remainder <= fix_r;
          busy      <= 1'b0;
          valid     <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed self-checking bench for div_iter_unit (WIDTH = 32).
module tb_div_iter_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int n_cmp = 0;
  int n_err = 0;

  div_iter_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .cancel    (cancel),
    .busy      (busy),
    .valid     (valid),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one operation at edge T0 and follows it edge by edge. Optional
  // events are applied before edge Tk: a stray start (poke_at), cancel, rst.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input int cancel_at, input int rst_at,
                        output int lat, output int busy_bad);
    lat = -1;
    busy_bad = 0;
    @(posedge clk); #1;
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == poke_at) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
      end
      if (k == cancel_at) cancel = 1'b1;
      if (k == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (k == cancel_at) begin
        cancel = 1'b0;
        check("cancel_busy", {31'd0, busy}, 32'd0);
        check("cancel_valid", {31'd0, valid}, 32'd0);
        return;
      end
      if (k == rst_at) begin
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        return;
      end
      if (valid) begin
        lat = k;
        return;
      end
      if (!busy) busy_bad++;
    end
  endtask

  task automatic do_vec(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_q,
                        input logic [31:0] exp_r, input logic early_ok);
    int lat, bb, exp_lat;
`ifdef DIV_EARLY_OUT_EN
    exp_lat = early_ok ? 1 : 33;
`else
    exp_lat = early_ok ? 33 : 33;
`endif
    run_op(s, a, b, 0, 0, 0, lat, bb);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, bb, 32'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, valid}, 32'd0);
  endtask

  task automatic expect_no_valid(input string tag, input int cycles);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    check(tag, seen, 32'd0);
  endtask

  initial begin
    int lat, bb;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);

    do_vec("divu_100_7",  1'b0, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0);
    do_vec("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_vec("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0);
    do_vec("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE, 1'b0);
    do_vec("div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0);
    do_vec("divu_5_0",    1'b0, 32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5,         1'b1);
    do_vec("div_m9_0",    1'b1, 32'hFFFF_FFF7, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFF7, 1'b1);
    do_vec("divu_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b0);

    // Cancel mid-operation: no pulse, previous results retained.
    run_op(1'b0, 32'd1000, 32'd3, 0, 10, 0, lat, bb);
    check("cancel_hold_q", quotient, 32'hFFFF_FFFF);
    check("cancel_hold_r", remainder, 32'd0);
    expect_no_valid("cancel_no_valid", 40);

    // Restart; a stray start during BUSY must not disturb the operation.
    run_op(1'b0, 32'd1000, 32'd3, 5, 0, 0, lat, bb);
    check("restart_q", quotient, 32'd333);
    check("restart_r", remainder, 32'd1);
    check("restart_lat", lat, 32'd33);
    @(posedge clk); #1;

    // Reset in the middle of a signed operation.
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 0, 20, lat, bb);
    expect_no_valid("rst_no_valid", 40);

    // start and cancel together in IDLE: cancel wins.
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    check("start_cancel_busy", {31'd0, busy}, 32'd0);
    expect_no_valid("start_cancel_no_valid", 40);

    do_vec("divu_3_9", 1'b0, 32'd3, 32'd9, 32'd0, 32'd3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
